// File: rtl/alu_param_pipe.sv
// alu_param_pipe: switch/button-driven ALU with a fixed two-cycle pipeline.
// Operands and the opcode are captured from i_switch on button rising edges.
// An operation runs only when a rising edge on i_start is seen while idle.
//
// Output contract: o_valid is a single-cycle pulse and there is no ready
// back-pressure. o_busy is high while an operation is in flight, and start
// edges seen during that time are dropped. o_result, o_flags and o_error
// change only in the cycle in which o_valid is high, or on reset.
module alu_param_pipe #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switch,
  input  logic [2:0]         i_enable,
  input  logic               i_start,
  output logic [NB_DATA-1:0] o_result,
  output logic [3:0]         o_flags,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_error
);

  // MIPS funct encodings
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SLT = NB_OP'(6'b101010);
  localparam logic [NB_OP-1:0] OP_SLL = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // FSM state, readable hierarchically for checkers
  state_t state_q;

  // Button history: _q is the registered button, _qq the cycle before
  logic [2:0] en_q, en_qq;
  logic       start_q, start_qq;
  logic [2:0] en_rise;
  logic       start_rise;
  logic       single_load;

  // Programmed registers
  logic [NB_DATA-1:0] reg_a, reg_b;
  logic [NB_OP-1:0]   reg_op;

  // Operands frozen at start so that later loads cannot disturb an operation
  logic [NB_DATA-1:0] snap_a, snap_b;
  logic [NB_OP-1:0]   snap_op;

  // Combinational ALU outputs, computed from the snapshot
  logic [NB_DATA-1:0] alu_res;
  logic [3:0]         alu_flags;
  logic               alu_legal;

  logic [NB_DATA:0]      sum_ext, diff_ext;
  logic [NB_SHAMT-1:0]   shamt;
  logic                  shift_big;
  logic                  alu_c, alu_v;

  assign en_rise     = en_q & ~en_qq;
  assign start_rise  = start_q & ~start_qq;
  assign single_load = (en_rise == 3'b001) || (en_rise == 3'b010) ||
                       (en_rise == 3'b100);

  // Register the buttons twice so that a rising edge is seen exactly once
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      en_q     <= 3'b000;
      en_qq    <= 3'b000;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      en_q     <= i_enable;
      en_qq    <= en_q;
      start_q  <= i_start;
      start_qq <= start_q;
    end
  end

  // Load A, opcode or B when exactly one load button has just risen
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
    end else if (single_load) begin
      if (en_rise[0]) reg_a  <= i_switch;
      if (en_rise[1]) reg_op <= i_switch[NB_OP-1:0];
      if (en_rise[2]) reg_b  <= i_switch;
    end
  end

  assign sum_ext   = {1'b0, snap_a} + {1'b0, snap_b};
  assign diff_ext  = {1'b0, snap_a} - {1'b0, snap_b};
  assign shamt     = snap_b[NB_SHAMT-1:0];
  assign shift_big = (snap_b >= SHIFT_LIMIT);

  // Result, carry and overflow for the snapshotted operation
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (snap_op)
      OP_ADD: begin
        alu_res = sum_ext[NB_DATA-1:0];
        alu_c   = sum_ext[NB_DATA];
        alu_v   = (snap_a[NB_DATA-1] == snap_b[NB_DATA-1]) &&
                  (sum_ext[NB_DATA-1] != snap_a[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[NB_DATA-1:0];
        // The extension bit of the difference is the borrow (A < B unsigned)
        alu_c   = diff_ext[NB_DATA];
        alu_v   = (snap_a[NB_DATA-1] != snap_b[NB_DATA-1]) &&
                  (diff_ext[NB_DATA-1] != snap_a[NB_DATA-1]);
      end
      OP_AND: alu_res = snap_a & snap_b;
      OP_OR:  alu_res = snap_a | snap_b;
      OP_XOR: alu_res = snap_a ^ snap_b;
      OP_NOR: alu_res = ~(snap_a | snap_b);
      OP_SLT: alu_res = {{(NB_DATA-1){1'b0}}, ($signed(snap_a) < $signed(snap_b))};
      OP_SLL: alu_res = shift_big ? '0 : (snap_a << shamt);
      OP_SRL: alu_res = shift_big ? '0 : (snap_a >> shamt);
      OP_SRA: alu_res = shift_big ? {NB_DATA{snap_a[NB_DATA-1]}}
                                  : NB_DATA'($signed(snap_a) >>> shamt);
      default: alu_legal = 1'b0;
    endcase
    alu_flags = {alu_res[NB_DATA-1], (alu_res == '0), alu_c, alu_v};
  end

  // Control FSM: snapshot on start, compute in EXEC, publish on entering DONE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      snap_a   <= '0;
      snap_b   <= '0;
      snap_op  <= '0;
      o_result <= '0;
      o_flags  <= 4'b0000;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            snap_a  <= reg_a;
            snap_b  <= reg_b;
            snap_op <= reg_op;
            o_busy  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // An illegal opcode keeps the previous result and flags
          if (alu_legal) begin
            o_result <= alu_res;
            o_flags  <= alu_flags;
          end
          o_error <= ~alu_legal;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
